wm_repack_27to32: RTL and testbench
===================================

# wm_repack_27to32

Width-conversion stage directly downstream of the `qxdqmrx` generator. It consumes the 27-bit `wm` words (`bit [2:4][1:3][2:4]`) and re-packs them, LSB-first and with no gaps, into 32-bit words shaped like `nllwipcvgy` (`[1:4][4:1][3:2]`) for the next `qxdqmrx` instance. A flush request drains any partial word, zero-padded and marked last.

## Interface
Parameters:
- `CNT_W`, default 16: width of the input and output word counters.

Ports (clock and reset first):
- `clk`  in  1  single clock; everything is on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `in_data`  in  `bit [2:4][1:3][2:4]` (27 bits)  input word.
- `in_valid`  in  1  `in_data` is valid.
- `in_ready`  out  1  block accepts the input word this cycle.
- `flush`  in  1  single-cycle pulse: drain the residual bits.
- `out_data`  out  `logic [1:4][4:1][3:2]` (32 bits)  packed output word.
- `out_valid`  out  1  `out_data` is valid.
- `out_last`  out  1  final word of a flush.
- `out_ready`  in  1  downstream accepts the output word.
- `busy`  out  1  a flush is in progress.
- `words_in`  out  `CNT_W`  count of accepted input words; wraps.
- `words_out`  out  `CNT_W`  count of emitted output words; wraps.

## Operation
- State: 64-bit accumulator `acc`, 7-bit fill count `cnt` (0..64), FSM {FILL, DRAIN}.
- Handshake transfer: `in_fire = in_valid & in_ready`; `out_fire = out_valid & out_ready`.
- `in_ready = (state==FILL) & (cnt <= 37) & ~rst`.
  - Depends on registered state only, never on `out_ready`.
  - Guarantees `cnt <= 64`.
- `out_valid = (cnt >= 32) | (state==DRAIN & cnt != 0)`.
- `out_data = acc[31:0]`. Bits at and above `cnt` are always 0, so a partial word is zero-padded.
- `out_last = (state==DRAIN) & (cnt <= 32) & out_valid`.
- Update rules:
  - On `out_fire`: `acc` shifts right by 32 and `cnt` decreases by `min(cnt, 32)`.
  - On `in_fire`: `in_data` is written at bit position `cnt'`, where `cnt'` is the count after any same-cycle shift. `cnt` increases by 27.
  - Simultaneous fire: net `cnt += 27 - 32`.
- Bit order: first-accepted word occupies the lowest bits. `in_data` flattens with `[2][1][2]` as its MSB.
- FSM:
  - FILL → DRAIN when `flush`=1.
  - DRAIN → FILL when `cnt` becomes 0. This covers `out_fire` of the last word, and also the cycle after entry if `cnt` was already 0, in which case nothing is emitted.
  - `flush` is ignored while in DRAIN.
  - `flush` and `in_fire` in the same cycle: the input word is accepted and included in the drain.
- `busy = (state==DRAIN)`.
- Counters increment by 1 on each fire and wrap modulo 2^`CNT_W`.
- Reset (synchronous; overrides all other activity, including mid-drain or mid-handshake):
  - `acc`=0, `cnt`=0, state=FILL, `words_in`=0, `words_out`=0.
  - Outputs while `rst`=1: `in_ready`=0, `out_valid`=0, `out_last`=0, `busy`=0, `out_data`=0.
  - Data in flight is discarded.

## Timing
- Latency: an output word becomes valid the cycle after the input that fills it to ≥32 bits is accepted.
- Throughput: no bubbles in steady state. With `out_ready`=1 throughout, 32 input words produce 27 output words, and `cnt` returns to 0.
- `out_data`/`out_valid` hold stable while `out_valid & ~out_ready`.
- `in_ready` first rises the cycle after `rst` deasserts.

## Structure
- Package `repack_pkg`:
  - `typedef bit [2:4][1:3][2:4] wm_word_t`
  - `typedef logic [1:4][4:1][3:2] nl_word_t`
  - `localparam IN_W=27, OUT_W=32, ACC_W=64, ACC_CNT_W=7`
  - `typedef enum logic {FILL, DRAIN} rp_state_e`
- One natural sub-module: `bit_accum`, holding the accumulator, shift, insert and count. The handshake FSM and counters stay in the top level.

## Test plan
- Two words, then flush:
  - `in_data`=27'h0000001 then 27'h7FFFFFF, `out_ready`=1 → `out_data`=32'hF8000001 (`out_last`=0).
  - Then `flush` → `out_data`=32'h003FFFFF, `out_last`=1, `busy` back to 0 one cycle later.
- Streaming: 32 random words with `out_ready`=1 → 27 words that bit-match an LSB-first golden concatenation; `cnt`=0 at end; `words_in`=32, `words_out`=27.
- Backpressure: `out_ready`=0 and continuous `in_valid` → exactly 2 words accepted (`cnt`=54); `in_ready`=0 until an output is taken; `out_data` stable throughout.
- Flush on empty and flush collisions:
  - `flush` with `cnt`=0 → no output; DRAIN lasts 1 cycle.
  - `flush` coinciding with `in_fire` of 27'h1 → a single word 32'h00000001 with `out_last`=1.
- Reset mid-drain: `rst` for 1 cycle while `out_valid`=1 → next cycle `out_valid`=0, counters 0, `in_ready`=1.
- Counter wrap: with `CNT_W`=4, accept 17 words → `words_in`=1.

Source files
------------

// File: rtl/repack_pkg.sv
// Shared types and constants for the 27-to-32 bit width converter.
// The typed count constants keep comparisons against the 7-bit fill count width-exact.
package repack_pkg;

  typedef bit [2:4][1:3][2:4] wm_word_t;
  typedef logic [1:4][4:1][3:2] nl_word_t;

  localparam int IN_W      = 27;
  localparam int OUT_W     = 32;
  localparam int ACC_W     = 64;
  localparam int ACC_CNT_W = 7;

  localparam logic [ACC_CNT_W-1:0] CNT_IN_W      = 7'd27;
  localparam logic [ACC_CNT_W-1:0] CNT_OUT_W     = 7'd32;
  // Highest fill that still leaves room for a whole input word.
  localparam logic [ACC_CNT_W-1:0] CNT_READY_MAX = 7'd37;

  typedef enum logic {FILL, DRAIN} rp_state_e;

  // Bits removed from the accumulator when an output word is taken.
  function automatic logic [ACC_CNT_W-1:0] take_bits(input logic [ACC_CNT_W-1:0] c);
    return (c >= CNT_OUT_W) ? CNT_OUT_W : c;
  endfunction

endpackage

// File: rtl/bit_accum.sv
// LSB-first bit accumulator: drops 32 bits on shift, appends 27 bits above the
// post-shift fill level on load. Bits at and above the fill level are kept at zero.
module bit_accum
  import repack_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 load,
  input  logic                 shift,
  input  logic [IN_W-1:0]      in_data,
  output logic [OUT_W-1:0]     acc_lo,
  output logic [ACC_CNT_W-1:0] cnt,
  output logic [ACC_CNT_W-1:0] cnt_next
);

  logic [ACC_W-1:0]     acc_q, acc_d, acc_sh;
  logic [ACC_CNT_W-1:0] cnt_q, cnt_d, cnt_sh;

  always_comb begin
    acc_sh = acc_q;
    cnt_sh = cnt_q;
    if (shift) begin
      acc_sh = acc_q >> OUT_W;
      cnt_sh = cnt_q - take_bits(cnt_q);
    end
    acc_d = acc_sh;
    cnt_d = cnt_sh;
    // The load lands on the post-shift level so a simultaneous take leaves no gap.
    if (load) begin
      acc_d = acc_sh | (ACC_W'(in_data) << cnt_sh);
      cnt_d = cnt_sh + CNT_IN_W;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      acc_q <= '0;
      cnt_q <= '0;
    end else begin
      acc_q <= acc_d;
      cnt_q <= cnt_d;
    end
  end

  assign acc_lo   = acc_q[OUT_W-1:0];
  assign cnt      = cnt_q;
  assign cnt_next = cnt_d;

endmodule

// File: rtl/wm_repack_27to32.sv
// Re-packs 27-bit wm words into gapless 32-bit words with flush-to-last draining.
// Handshake FSM and word counters live here; bit storage is in bit_accum.
module wm_repack_27to32
  import repack_pkg::*;
#(
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  wm_word_t         in_data,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             flush,
  output nl_word_t         out_data,
  output logic             out_valid,
  output logic             out_last,
  input  logic             out_ready,
  output logic             busy,
  output logic [CNT_W-1:0] words_in,
  output logic [CNT_W-1:0] words_out
);

  rp_state_e            state_q, state_d;
  logic [ACC_CNT_W-1:0] cnt, cnt_next;
  logic [OUT_W-1:0]     acc_lo;
  logic                 in_fire, out_fire;
  logic [CNT_W-1:0]     words_in_q, words_out_q;

  assign in_fire  = in_valid & in_ready;
  assign out_fire = out_valid & out_ready;

  bit_accum u_accum (
    .clk      (clk),
    .rst      (rst),
    .load     (in_fire),
    .shift    (out_fire),
    .in_data  (in_data),
    .acc_lo   (acc_lo),
    .cnt      (cnt),
    .cnt_next (cnt_next)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= FILL;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      FILL:  if (flush) state_d = DRAIN;
      // Also leaves after one cycle when a flush found the accumulator empty.
      DRAIN: if (cnt_next == '0) state_d = FILL;
    endcase
  end

  always_comb begin
    in_ready  = 1'b0;
    out_valid = 1'b0;
    out_last  = 1'b0;
    busy      = 1'b0;
    out_data  = '0;
    if (!rst) begin
      in_ready  = (state_q == FILL) && (cnt <= CNT_READY_MAX);
      out_valid = (cnt >= CNT_OUT_W) || ((state_q == DRAIN) && (cnt != '0));
      out_last  = (state_q == DRAIN) && (cnt <= CNT_OUT_W) && out_valid;
      busy      = (state_q == DRAIN);
      out_data  = acc_lo;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      words_in_q  <= '0;
      words_out_q <= '0;
    end else begin
      if (in_fire)  words_in_q  <= words_in_q + CNT_W'(1);
      if (out_fire) words_out_q <= words_out_q + CNT_W'(1);
    end
  end

  assign words_in  = words_in_q;
  assign words_out = words_out_q;

endmodule

// File: tb/tb_wm_repack_27to32.sv
// Bench for wm_repack_27to32: directed table, multi-cycle corner sequences and random
// traffic checked every cycle against a bit-queue reference model.
module tb_wm_repack_27to32;
  import repack_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic [26:0] in_data;
  logic        in_valid, flush, out_ready;
  logic        in_ready, out_valid, out_last, busy;
  logic [31:0] out_data;
  logic [15:0] words_in, words_out;
  logic        in_ready4, out_valid4, out_last4, busy4;
  logic [31:0] out_data4;
  logic [3:0]  words_in4, words_out4;

  int n_vec  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  wm_repack_27to32 dut (
    .clk       (clk),
    .rst       (rst),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .flush     (flush),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_last  (out_last),
    .out_ready (out_ready),
    .busy      (busy),
    .words_in  (words_in),
    .words_out (words_out)
  );

  // Narrow-counter copy sharing the same stimulus, for counter wrap.
  wm_repack_27to32 #(.CNT_W(4)) dut4 (
    .clk       (clk),
    .rst       (rst),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_ready  (in_ready4),
    .flush     (flush),
    .out_data  (out_data4),
    .out_valid (out_valid4),
    .out_last  (out_last4),
    .out_ready (out_ready),
    .busy      (busy4),
    .words_in  (words_in4),
    .words_out (words_out4)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %0h, expected %0h", name, $time, act, exp);
    end
  endtask

  // Reference model: the accumulator is a queue of bits, oldest bit first.
  bit          mq[$];
  bit          mdrain = 1'b0;
  int unsigned m_win  = 0;
  int unsigned m_wout = 0;
  bit          chk_en = 1'b0;

  function automatic bit m_in_ready();
    return !rst && !mdrain && (mq.size() <= 37);
  endfunction

  function automatic bit m_out_valid();
    return !rst && ((mq.size() >= 32) || (mdrain && mq.size() != 0));
  endfunction

  function automatic bit m_out_last();
    return m_out_valid() && mdrain && (mq.size() <= 32);
  endfunction

  function automatic logic [31:0] m_out_data();
    logic [31:0] r;
    r = '0;
    if (!rst) for (int i = 0; i < 32 && i < mq.size(); i++) r[i] = mq[i];
    return r;
  endfunction

  task automatic model_check();
    if (!chk_en) return;
    check("in_ready", in_ready, m_in_ready());
    check("out_valid", out_valid, m_out_valid());
    check("out_last", out_last, m_out_last());
    check("busy", busy, !rst && mdrain);
    check("out_data", out_data, m_out_data());
    check("words_in", words_in, m_win % 65536);
    check("words_out", words_out, m_wout % 65536);
    check("words_in4", words_in4, m_win % 16);
    check("words_out4", words_out4, m_wout % 16);
  endtask

  task automatic model_update();
    bit ir, ov;
    int take;
    if (rst) begin
      mq.delete();
      mdrain = 1'b0;
      m_win  = 0;
      m_wout = 0;
    end else begin
      ir = m_in_ready();
      ov = m_out_valid();
      if (ov && out_ready) begin
        take = (mq.size() < 32) ? mq.size() : 32;
        for (int i = 0; i < take; i++) void'(mq.pop_front());
        m_wout++;
      end
      if (in_valid && ir) begin
        for (int i = 0; i < 27; i++) mq.push_back(in_data[i]);
        m_win++;
      end
      if (!mdrain) begin
        if (flush) mdrain = 1'b1;
      end else if (mq.size() == 0) begin
        mdrain = 1'b0;
      end
    end
  endtask

  // Inputs change 1 after the edge; outputs are compared 2 after it.
  task automatic clock_edge();
    #1;
    model_check();
    @(posedge clk);
    model_update();
    #1;
  endtask

  task automatic set_in(input logic r, input logic iv, input logic [26:0] d, input logic fl,
                        input logic ordy);
    rst       = r;
    in_valid  = iv;
    in_data   = d;
    flush     = fl;
    out_ready = ordy;
  endtask

  task automatic do_reset();
    set_in(1'b1, 1'b0, '0, 1'b0, 1'b1);
    clock_edge();
    rst = 1'b0;
  endtask

  typedef struct {
    logic        rst;
    logic        iv;
    logic [26:0] d;
    logic        fl;
    logic        ordy;
    logic [31:0] e_data;
    logic        e_ov;
    logic        e_last;
    logic        e_ir;
    logic        e_busy;
    int          e_win;
    int          e_wout;
  } vec_t;

  function automatic vec_t mk(input logic r, input logic iv, input logic [26:0] d,
                              input logic fl, input logic ordy, input logic [31:0] ed,
                              input logic eov, input logic el, input logic eir,
                              input logic eb, input int ewi, input int ewo);
    vec_t v;
    v.rst = r;  v.iv = iv;  v.d = d;  v.fl = fl;  v.ordy = ordy;
    v.e_data = ed;  v.e_ov = eov;  v.e_last = el;  v.e_ir = eir;  v.e_busy = eb;
    v.e_win = ewi;  v.e_wout = ewo;
    return v;
  endfunction

  vec_t        tbl[16];
  logic [26:0] w[32];
  logic [863:0] gold;
  logic [31:0] outs[$];
  logic [31:0] held;
  logic [26:0] bp_w[$];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // rst  iv  data          fl ordy  e_data        ov last ir busy win wout
    tbl[0]  = mk(1, 0, 27'h0,       0, 1, 32'h0,        0, 0, 0, 0, 0, 0);
    tbl[1]  = mk(0, 1, 27'h1,       0, 1, 32'h0,        0, 0, 1, 0, 0, 0);
    tbl[2]  = mk(0, 1, 27'h7FFFFFF, 0, 1, 32'h1,        0, 0, 1, 0, 1, 0);
    tbl[3]  = mk(0, 0, 27'h0,       0, 1, 32'hF8000001, 1, 0, 0, 0, 2, 0);
    tbl[4]  = mk(0, 0, 27'h0,       1, 1, 32'h003FFFFF, 0, 0, 1, 0, 2, 1);
    tbl[5]  = mk(0, 0, 27'h0,       0, 1, 32'h003FFFFF, 1, 1, 0, 1, 2, 1);
    tbl[6]  = mk(0, 0, 27'h0,       0, 1, 32'h0,        0, 0, 1, 0, 2, 2);
    tbl[7]  = mk(0, 0, 27'h0,       1, 1, 32'h0,        0, 0, 1, 0, 2, 2);
    tbl[8]  = mk(0, 0, 27'h0,       0, 1, 32'h0,        0, 0, 0, 1, 2, 2);
    tbl[9]  = mk(0, 0, 27'h0,       0, 1, 32'h0,        0, 0, 1, 0, 2, 2);
    tbl[10] = mk(0, 1, 27'h1,       1, 1, 32'h0,        0, 0, 1, 0, 2, 2);
    tbl[11] = mk(0, 0, 27'h0,       0, 1, 32'h1,        1, 1, 0, 1, 3, 2);
    tbl[12] = mk(0, 0, 27'h0,       0, 1, 32'h0,        0, 0, 1, 0, 3, 3);
    tbl[13] = mk(0, 1, 27'h5555555, 1, 0, 32'h0,        0, 0, 1, 0, 3, 3);
    tbl[14] = mk(1, 0, 27'h0,       0, 0, 32'h0,        0, 0, 0, 0, 4, 3);
    tbl[15] = mk(0, 0, 27'h0,       0, 1, 32'h0,        0, 0, 1, 0, 0, 0);

    set_in(1'b1, 1'b0, '0, 1'b0, 1'b0);
    @(posedge clk);
    model_update();
    #1;
    chk_en = 1'b1;

    for (int r = 0; r < 16; r++) begin
      set_in(tbl[r].rst, tbl[r].iv, tbl[r].d, tbl[r].fl, tbl[r].ordy);
      #1;
      check($sformatf("tbl%0d_out_data", r), out_data, tbl[r].e_data);
      check($sformatf("tbl%0d_out_valid", r), out_valid, tbl[r].e_ov);
      check($sformatf("tbl%0d_out_last", r), out_last, tbl[r].e_last);
      check($sformatf("tbl%0d_in_ready", r), in_ready, tbl[r].e_ir);
      check($sformatf("tbl%0d_busy", r), busy, tbl[r].e_busy);
      check($sformatf("tbl%0d_words_in", r), words_in, tbl[r].e_win);
      check($sformatf("tbl%0d_words_out", r), words_out, tbl[r].e_wout);
      clock_edge();
    end

    // Backpressure: no output taken, continuous input offered.
    begin
      int  acc_cnt;
      bit  have;
      acc_cnt = 0;
      have    = 1'b0;
      do_reset();
      set_in(1'b0, 1'b1, '0, 1'b0, 1'b0);
      for (int c = 0; c < 8; c++) begin
        in_data = 27'($urandom());
        #1;
        if (in_ready) begin
          acc_cnt++;
          bp_w.push_back(in_data);
        end
        if (out_valid) begin
          if (!have) begin
            held = out_data;
            have = 1'b1;
          end else begin
            check("bp_out_data_stable", out_data, held);
          end
        end
        clock_edge();
      end
      check("bp_accepted", acc_cnt, 2);
      check("bp_words_in", words_in, 2);
      check("bp_in_ready_low", in_ready, 0);
      if (bp_w.size() == 2) check("bp_first_word", held, {bp_w[1][4:0], bp_w[0]});
      in_valid  = 1'b0;
      out_ready = 1'b1;
      #1;
      check("bp_in_ready_during_take", in_ready, 0);
      clock_edge();
      check("bp_in_ready_after_take", in_ready, 1);
    end

    // Streaming: 32 words in, 27 words out, nothing left behind.
    begin
      int k, got, guard;
      bit acc_now;
      k = 0;
      got = 0;
      guard = 0;
      do_reset();
      for (int i = 0; i < 32; i++) begin
        w[i] = 27'($urandom());
        gold[i*27 +: 27] = w[i];
      end
      out_ready = 1'b1;
      while ((k < 32 || got < 27) && guard < 400) begin
        in_valid = (k < 32);
        if (k < 32) in_data = w[k];
        #1;
        acc_now = in_valid && in_ready;
        if (out_valid && out_ready) begin
          outs.push_back(out_data);
          got++;
        end
        clock_edge();
        if (acc_now) k++;
        guard++;
      end
      in_valid = 1'b0;
      check("stream_out_count", got, 27);
      for (int j = 0; j < 27 && j < outs.size(); j++)
        check($sformatf("stream_word%0d", j), outs[j], gold[j*32 +: 32]);
      check("stream_words_in", words_in, 32);
      check("stream_words_out", words_out, 27);
      check("stream_cnt_zero", dut.u_accum.cnt, 0);
    end

    // Counter wrap on the 4-bit instance.
    begin
      int acc_cnt, guard;
      acc_cnt = 0;
      guard = 0;
      do_reset();
      out_ready = 1'b1;
      while (acc_cnt < 17 && guard < 200) begin
        in_valid = 1'b1;
        in_data  = 27'($urandom());
        #1;
        if (in_ready) acc_cnt++;
        clock_edge();
        guard++;
      end
      in_valid = 1'b0;
      check("wrap_accepted", acc_cnt, 17);
      check("wrap_words_in4", words_in4, 1);
      check("wrap_words_in16", words_in, 17);
    end

    // Random traffic with occasional flush and reset.
    for (int c = 0; c < 400; c++) begin
      rst       = ($urandom_range(0, 99) == 0);
      in_valid  = ($urandom_range(0, 9) < 7);
      in_data   = 27'($urandom());
      flush     = ($urandom_range(0, 15) == 0);
      out_ready = ($urandom_range(0, 9) < 6);
      clock_edge();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
